ir_frame_decoder: RTL

- Parametrised successor to the VCR IR read state machine.
- Samples the raw IR line synchronously and measures each high-pulse width in clk cycles.
- Classifies each pulse as logic 0, logic 1 or invalid, and assembles NBITS bits into a frame.
- Delivers frames over a valid/ready handshake with a one-entry holding register; reports malformed, truncated and overrun frames via an error strobe.

---
 rtl/ir_pkg.sv | 20 ++
 rtl/ir_sync_edge.sv | 35 +++
 rtl/ir_frame_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types for the IR frame decoder: FSM states and error codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_WIDTH    = 3'd1,
    ERR_HIGH_TIMEOUT = 3'd2,
    ERR_GAP_TIMEOUT  = 3'd3,
    ERR_OVERRUN      = 3'd4
  } err_t;

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchroniser for the raw IR line plus registered edge detector.
// Latency: ir to rise/fall/level is 3 clk cycles.
// Backpressure: none; free-running sampler.
// Ports: clk, readReset (async, active-high), ir (async raw line),
//        level (synchronised line, aligned with rise/fall), rise, fall (1-cycle pulses).
module ir_sync_edge (
  input  logic clk,
  input  logic readReset,
  input  logic ir,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  // level doubles as the delayed copy of s2, so rise/fall line up with it.
  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= ir;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

// File: rtl/ir_frame_decoder.sv
// IR pulse-width decoder: classifies high pulses as 0/1, assembles NBITS-bit frames.
// Latency: frame lands in the holding register 4 cycles after the last ir fall.
// Backpressure: one-entry holding register; a completion while it is full and not
//               being consumed drops the new frame and strobes ERR_OVERRUN.
// Ports: clk, readReset (async, active-high), enable (arm decoder), ir (raw line),
//        frame_valid/frame_ready/frame_data (frame handshake), err_valid/err_code
//        (one-cycle error strobe), busy (FSM not IDLE).
module ir_frame_decoder
  import ir_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int CNT_W     = 9,
  parameter int ZERO_MIN  = 1,
  parameter int ZERO_MAX  = 9,
  parameter int ONE_MIN   = 13,
  parameter int ONE_MAX   = 18,
  parameter int HIGH_MAX  = 32,
  parameter int GAP_MAX   = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             readReset,
  input  logic             enable,
  input  logic             ir,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [NBITS-1:0] frame_data,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             busy
);

  localparam int BC_W = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0] C_ZMIN = CNT_W'(ZERO_MIN);
  localparam logic [CNT_W-1:0] C_ZMAX = CNT_W'(ZERO_MAX);
  localparam logic [CNT_W-1:0] C_OMIN = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] C_OMAX = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0] C_HMAX = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] C_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [BC_W-1:0]  C_LAST = BC_W'(NBITS - 1);

  if (ZERO_MAX >= ONE_MIN || ONE_MAX >= HIGH_MAX ||
      HIGH_MAX >= (1 << CNT_W) || GAP_MAX >= (1 << CNT_W)) begin : g_param_check
    $error("ir_frame_decoder: inconsistent pulse timing parameters");
  end

  logic level;
  logic rise;
  logic fall;

  ir_sync_edge u_sync (
    .clk       (clk),
    .readReset (readReset),
    .ir        (ir),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BC_W-1:0]  bit_count;
  logic [NBITS-1:0] shreg;

  logic             is_zero;
  logic             is_one;
  logic [NBITS-1:0] sh_next;

  // cnt equals the high width w in the cycle the fall is seen.
  always_comb begin
    is_zero = (cnt >= C_ZMIN) && (cnt <= C_ZMAX);
    is_one  = (cnt >= C_OMIN) && (cnt <= C_OMAX);
    if (MSB_FIRST)
      sh_next = {shreg[NBITS-2:0], is_one};
    else
      sh_next = {is_one, shreg[NBITS-1:1]};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge readReset) begin
    if (readReset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_count   <= '0;
      shreg       <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;

      // Consumption; a completion in the same cycle reasserts valid below.
      if (frame_valid && frame_ready)
        frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && rise) begin
            state     <= HIGH;
            cnt       <= C_ONE;
            bit_count <= '0;
            shreg     <= '0;
          end
        end

        HIGH: begin
          if (!enable) begin
            state <= IDLE;
          end else if (fall) begin
            if (is_zero || is_one) begin
              shreg     <= sh_next;
              bit_count <= bit_count + BC_W'(1);
              if (bit_count == C_LAST) begin
                state <= IDLE;
                if (!frame_valid || frame_ready) begin
                  frame_data  <= sh_next;
                  frame_valid <= 1'b1;
                end else begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_OVERRUN;
                end
              end else begin
                state <= LOW;
                cnt   <= C_ONE;
              end
            end else begin
              state     <= IDLE;
              err_valid <= 1'b1;
              err_code  <= ERR_BAD_WIDTH;
            end
          end else if (level && cnt == C_HMAX) begin
            // Stuck line: IDLE only re-arms on a fresh rising edge.
            state     <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_HIGH_TIMEOUT;
          end else if (cnt != C_SAT) begin
            cnt <= cnt + C_ONE;
          end
        end

        LOW: begin
          if (!enable) begin
            state <= IDLE;
          end else if (rise) begin
            state <= HIGH;
            cnt   <= C_ONE;
          end else if (cnt == C_GMAX) begin
            state     <= IDLE;
            err_valid <= 1'b1;
            err_code  <= ERR_GAP_TIMEOUT;
          end else if (cnt != C_SAT) begin
            cnt <= cnt + C_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
